// File: rtl/alu_cmd_master.sv
// Command-side master for the registered 4-bit ALU: one command in flight.
// Optional divide-by-zero flag output enabled by defining ALU_DIV0_FLAG_EN.
module alu_cmd_master #(
  parameter int ALU_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [2:0] cmd_op,
  output logic [7:0] alu_ui,
  output logic [2:0] alu_sel,
  input  logic [7:0] alu_res,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
`ifdef ALU_DIV0_FLAG_EN
  output logic       rsp_err,
`endif
  output logic [2:0] rsp_op,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [7:0]  ui_q;
  logic [2:0]  sel_q;
  logic [7:0]  data_q;
  logic [2:0]  op_q;
  logic        vld_q;
  logic        err_q;

  // Counter runs L..0 so the result is sampled L+1 edges after
  // the operands are driven (ALU input reg + output reg + our capture).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ui_q    <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      op_q    <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            ui_q    <= {cmd_b, cmd_a};
            sel_q   <= cmd_op;
            op_q    <= cmd_op;
            cnt_q   <= 4'(ALU_LATENCY);
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            data_q  <= alu_res;
            err_q   <= (sel_q == 3'd7) && (ui_q[7:4] == 4'd0);
            vld_q   <= 1'b1;
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = rst_n & (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign alu_ui    = ui_q;
  assign alu_sel   = sel_q;
  assign rsp_valid = vld_q;
  assign rsp_data  = data_q;
  assign rsp_op    = op_q;
`ifdef ALU_DIV0_FLAG_EN
  assign rsp_err   = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_alu_cmd_master.sv
// Directed bench for alu_cmd_master with a 2-stage registered ALU stand-in.
// Build with ALU_DIV0_FLAG_EN defined to also check rsp_err.
`timescale 1ns/1ps
module tb_alu_cmd_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [2:0] cmd_op;
  logic [7:0] alu_ui;
  logic [2:0] alu_sel;
  logic [7:0] alu_res = '0;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [2:0] rsp_op;
  logic       busy;
  logic       rsp_err_w;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_cmd_master #(.ALU_LATENCY(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .alu_ui    (alu_ui),
    .alu_sel   (alu_sel),
    .alu_res   (alu_res),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
`ifdef ALU_DIV0_FLAG_EN
    .rsp_err   (rsp_err_w),
`endif
    .rsp_op    (rsp_op),
    .busy      (busy)
  );

`ifndef ALU_DIV0_FLAG_EN
  assign rsp_err_w = 1'b0;
`endif

  // ALU stand-in: input register then output register
  logic [10:0] alu_in_q = '0;

  function automatic logic [7:0] alu_f(input logic [10:0] x);
    logic [7:0] a, b;
    a = {4'd0, x[3:0]};
    b = {4'd0, x[7:4]};
    case (x[10:8])
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~x[7:0];
      3'd6: return a * b;
      default: return (b == 8'd0) ? 8'd0 : a / b;
    endcase
  endfunction

  always @(posedge clk) begin
    alu_in_q <= {alu_sel, alu_ui};
    alu_res  <= alu_f(alu_in_q);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command, wait for acceptance, check the driven operands.
  task automatic issue(input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input string tag);
    int n;
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, " ready_to"}, 32'(n < 20), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check({tag, " ui"}, 32'(alu_ui), 32'({b, a}));
    check({tag, " sel"}, 32'(alu_sel), 32'(op));
    check({tag, " busy"}, 32'(busy), 32'd1);
    check({tag, " cready"}, 32'(cmd_ready), 32'd0);
  endtask

  // Response must appear exactly 3 edges after acceptance.
  task automatic expect_rsp(input logic [7:0] data, input logic [2:0] op,
                            input logic err, input string tag);
    tick();
    tick();
    check({tag, " early"}, 32'(rsp_valid), 32'd0);
    tick();
    check({tag, " valid"}, 32'(rsp_valid), 32'd1);
    check({tag, " data"}, 32'(rsp_data), 32'(data));
    check({tag, " op"}, 32'(rsp_op), 32'(op));
`ifdef ALU_DIV0_FLAG_EN
    check({tag, " err"}, 32'(rsp_err_w), 32'(err));
`else
    if (err) check({tag, " err_off"}, 32'(rsp_err_w), 32'd0);
`endif
  endtask

  task automatic take_rsp(input string tag);
    rsp_ready = 1'b1;
    tick();
    check({tag, " drop"}, 32'(rsp_valid), 32'd0);
    check({tag, " idle"}, 32'(cmd_ready), 32'd1);
    check({tag, " errclr"}, 32'(rsp_err_w), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b1;
    cmd_a = 4'd3;
    cmd_b = 4'd5;
    cmd_op = 3'd0;
    rsp_ready = 1'b0;
    tick();
    tick();
    check("rst cready", 32'(cmd_ready), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst ui", 32'(alu_ui), 32'd0);
    check("rst sel", 32'(alu_sel), 32'd0);
    check("rst rvalid", 32'(rsp_valid), 32'd0);
    check("rst rdata", 32'(rsp_data), 32'd0);
    check("rst rop", 32'(rsp_op), 32'd0);
    check("rst err", 32'(rsp_err_w), 32'd0);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post cready", 32'(cmd_ready), 32'd1);
    check("post busy", 32'(busy), 32'd0);

    rsp_ready = 1'b1;
    issue(4'd3, 4'd5, 3'd0, "add");
    check("add ui53", 32'(alu_ui), 32'h53);
    expect_rsp(8'h08, 3'd0, 1'b0, "add");
    take_rsp("add");

    issue(4'd3, 4'd5, 3'd1, "sub");
    expect_rsp(8'hFE, 3'd1, 1'b0, "sub");
    take_rsp("sub");
    issue(4'd15, 4'd15, 3'd6, "mul");
    expect_rsp(8'hE1, 3'd6, 1'b0, "mul");
    take_rsp("mul");
    issue(4'd3, 4'd5, 3'd5, "not");
    expect_rsp(8'hAC, 3'd5, 1'b0, "not");
    take_rsp("not");

    // Backpressure with a second command waiting
    rsp_ready = 1'b0;
    issue(4'd7, 4'd6, 3'd2, "and");
    expect_rsp(8'h06, 3'd2, 1'b0, "and");
    cmd_valid = 1'b1;
    cmd_a = 4'hA;
    cmd_b = 4'hC;
    cmd_op = 3'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp valid", 32'(rsp_valid), 32'd1);
      check("bp data", 32'(rsp_data), 32'h06);
      check("bp op", 32'(rsp_op), 32'd2);
      check("bp cready", 32'(cmd_ready), 32'd0);
      check("bp ui", 32'(alu_ui), 32'h67);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp drop", 32'(rsp_valid), 32'd0);
    check("bp ui_held", 32'(alu_ui), 32'h67);
    check("bp cready", 32'(cmd_ready), 32'd1);
    issue(4'hA, 4'hC, 3'd3, "or");
    expect_rsp(8'h0E, 3'd3, 1'b0, "or");
    take_rsp("or");

    issue(4'd9, 4'd0, 3'd7, "div0");
    expect_rsp(8'h00, 3'd7, 1'b1, "div0");
    take_rsp("div0");
    issue(4'd9, 4'd2, 3'd7, "div");
    expect_rsp(8'h04, 3'd7, 1'b0, "div");
    take_rsp("div");

    // Reset while waiting on the ALU
    issue(4'd1, 4'd2, 3'd0, "abort");
    tick();
    rst_n = 1'b0;
    tick();
    check("abort busy", 32'(busy), 32'd0);
    check("abort cready", 32'(cmd_ready), 32'd0);
    check("abort ui", 32'(alu_ui), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("abort novalid", 32'(rsp_valid), 32'd0);
      tick();
    end
    issue(4'hC, 4'h5, 3'd4, "xor");
    expect_rsp(8'h09, 3'd4, 1'b0, "xor");
    take_rsp("xor");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
